mac_accum_stage: RTL and testbench
==================================

Name: mac_accum_stage

Overview:
- Downstream consumer of the booth multiplier result stream.
- Accepts 64-bit products over a valid/ready handshake and accumulates them into a wide signed/unsigned running sum.
- Emits the final sum, beat count and overflow flag over a second valid/ready handshake when a group ends.
- Turns the multiplier into a multiply-accumulate datapath for dot-product style workloads.

Parameters:
- ACC_W, 72, accumulator/output sum width (>= 64).
- CNT_W, 16, beat-counter width; a group is force-closed at 2^CNT_W-1 beats.
- SIGNED, 1, 1 = in_res is two's complement and is sign-extended; 0 = unsigned, zero-extended.
- SAT, 0, 1 = clamp on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  product beat available (driven by multiplier valid_o).
- in_ready  output  1  stage can accept a beat (drives multiplier ready_i).
- in_res  input  64  product from multiplier.
- in_last  input  1  beat closes the current group.
- out_valid  output  1  group result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  ACC_W  accumulated sum of the group.
- out_count  output  CNT_W  number of beats in the group.
- out_ovf  output  1  sticky: at least one add in the group overflowed.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=ACC, acc=0, count=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0. in_ready=1 in the first cycle after reset.
- Reset mid-group discards the partial sum. Reset while out_valid=1 drops the pending result without a handshake.
- FSM has two states, ACC and HOLD.
- ACC state:
  - in_ready=1, out_valid=0.
  - Beat accepted when in_valid & in_ready.
  - On accept: ext = SIGNED ? sign-extend(in_res) : zero-extend(in_res) to ACC_W. acc <= acc+ext; count <= count+1.
- Overflow detection:
  - SIGNED=1: operands same sign and result sign differs.
  - SIGNED=0: carry out of bit ACC_W-1.
  - On overflow: ovf <= 1 (sticky for the group).
  - If SAT=1, acc <= max (or min for a negative signed overflow) instead of the wrapped sum. Max is 2^(ACC_W-1)-1 signed, 2^ACC_W-1 unsigned. Min is -2^(ACC_W-1).
- Group close:
  - Triggered when the accepted beat has in_last=1, or when count+1 == 2^CNT_W-1 (forced flush).
  - On close, next cycle: state=HOLD, out_valid=1. out_sum/out_count/out_ovf carry the values that include the closing beat.
  - Latency from the last beat's accept edge to out_valid is 1 cycle.
- HOLD state:
  - in_ready=0; no beats accepted; upstream stalls.
  - Outputs stable while out_valid & !out_ready.
  - On out_valid & out_ready: next cycle out_valid=0, acc=0, count=0, ovf=0, state=ACC, in_ready=1.
  - A one-cycle bubble between groups is intended.
- in_valid with no accept (HOLD) has no effect. in_res/in_last are ignored when not accepted.
- in_valid is not required to stay high between beats; idle cycles inside a group do not affect the sum.
- Single-beat groups (in_last on the first beat) are legal: out_count=1.
- out_* registers hold their last value after the handshake until the next close. Consumers must qualify them with out_valid.

Test Plan:
- Default params; beats 6, -10 (0xFFFF_FFFF_FFFF_FFF6), 100 with last on the 3rd, out_ready=1 -> out_valid one cycle after 3rd accept, out_sum=96, out_count=3, out_ovf=0; in_ready back to 1 the cycle after handoff.
- Same group with out_ready=0 for 5 cycles after out_valid -> out_sum=96 held stable, in_ready=0 throughout while in_valid=1 with beat 7 pending. Raise out_ready -> 7 accepted as first beat of the next group, next out_sum=7 with last.
- ACC_W=64, SIGNED=1, SAT=1: beats 0x7FFF_FFFF_FFFF_FFFF, 1(last) -> out_sum=0x7FFF_FFFF_FFFF_FFFF, out_ovf=1. Repeat with SAT=0 -> out_sum=0x8000_0000_0000_0000, out_ovf=1.
- CNT_W=4, beats of value 2, in_last never set -> forced close after 15th beat: out_sum=30, out_count=15. The 16th beat starts a new group.
- rst asserted for 1 cycle after 2 accepted beats (5, 5) -> all outputs 0. Next group 3(last) gives out_sum=3, out_count=1.
- SIGNED=0: beats 0xFFFF_FFFF_FFFF_FFFF twice (last on 2nd) -> out_sum=0x1_FFFF_FFFF_FFFF_FFFE, out_ovf=0.

Source files
------------

// File: rtl/mac_accum_stage.sv
// mac_accum_stage: accumulates a stream of 64-bit multiplier products into a
// wide running sum and hands the group result downstream when the group ends.
//
// Ports:
//   clk        single clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   product beat available
//   in_ready   stage can accept a beat (low while a result is pending)
//   in_res     64-bit product (signed or unsigned per SIGNED)
//   in_last    accepted beat closes the current group
//   out_valid  group result available
//   out_ready  consumer accepts the result
//   out_sum    accumulated sum of the group (ACC_W bits)
//   out_count  number of beats in the group (CNT_W bits)
//   out_ovf    at least one add in the group overflowed
//
// A group also closes by itself when its beat count reaches 2^CNT_W-1.
module mac_accum_stage #(
  parameter int unsigned ACC_W  = 72,
  parameter int unsigned CNT_W  = 16,
  parameter bit          SIGNED = 1'b1,
  parameter bit          SAT    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_res,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {
    S_ACC  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum_wrap;
  logic [ACC_W-1:0] sat_val;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             carry;
  logic             add_ovf;
  logic             ovf_nxt;
  logic             close;
  logic             accept;

  // Next accumulator value, overflow detection and group-close decision
  always_comb begin
    ext       = '0;
    sum_wrap  = '0;
    carry     = 1'b0;
    add_ovf   = 1'b0;
    sat_val   = '1;
    acc_nxt   = '0;
    ovf_nxt   = 1'b0;
    count_nxt = '0;
    close     = 1'b0;

    if (SIGNED) begin
      ext = ACC_W'($signed(in_res));
    end else begin
      ext = ACC_W'(in_res);
    end

    {carry, sum_wrap} = {1'b0, acc} + {1'b0, ext};

    if (SIGNED) begin
      add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum_wrap[ACC_W-1] != acc[ACC_W-1]);
      // Signed overflow only happens with equal operand signs, so acc's sign picks the rail
      sat_val = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      add_ovf = carry;
      sat_val = '1;
    end

    acc_nxt   = (SAT && add_ovf) ? sat_val : sum_wrap;
    ovf_nxt   = ovf | add_ovf;
    count_nxt = count + CNT_W'(1);
    // All-ones count is the forced-flush point
    close     = in_last || (count_nxt == {CNT_W{1'b1}});
  end

  assign accept = in_valid & in_ready;

  // Two-state control: accumulate beats, then hold the result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ACC;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (accept) begin
            acc   <= acc_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
            if (close) begin
              state     <= S_HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= acc_nxt;
              out_count <= count_nxt;
              out_ovf   <= ovf_nxt;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state     <= S_ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
          end
        end
        default: begin
          state <= S_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accum_stage.sv
// Scoreboard bench for mac_accum_stage across several parameter sets.
module tb_mac_accum_stage;

  localparam int unsigned NI = 5;

  typedef struct packed {
    logic [71:0] sum;
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [NI-1:0] in_valid;
  logic [NI-1:0] in_last;
  logic [NI-1:0] out_ready;
  logic [NI-1:0] in_ready;
  logic [NI-1:0] out_valid;
  logic [NI-1:0] out_ovf;
  logic [63:0]   in_res    [NI];
  logic [71:0]   out_sum   [NI];
  logic [15:0]   out_count [NI];

  logic [63:0] sum_1, sum_2;
  logic [3:0]  cnt_3;

  exp_t exp_q [NI][$];
  int   checks;
  int   passes;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: defaults
  mac_accum_stage u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_res(in_res[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_sum(out_sum[0]), .out_count(out_count[0]),
    .out_ovf(out_ovf[0]));

  // 1: 64-bit signed, saturating
  mac_accum_stage #(.ACC_W(64), .CNT_W(16), .SIGNED(1'b1), .SAT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_res(in_res[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_sum(sum_1), .out_count(out_count[1]),
    .out_ovf(out_ovf[1]));

  // 2: 64-bit signed, wrapping
  mac_accum_stage #(.ACC_W(64), .CNT_W(16), .SIGNED(1'b1), .SAT(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_res(in_res[2]), .in_last(in_last[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_sum(sum_2), .out_count(out_count[2]),
    .out_ovf(out_ovf[2]));

  // 3: 4-bit beat counter
  mac_accum_stage #(.ACC_W(72), .CNT_W(4), .SIGNED(1'b1), .SAT(1'b0)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_res(in_res[3]), .in_last(in_last[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .out_sum(out_sum[3]), .out_count(cnt_3),
    .out_ovf(out_ovf[3]));

  // 4: unsigned
  mac_accum_stage #(.ACC_W(72), .CNT_W(16), .SIGNED(1'b0), .SAT(1'b0)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[4]), .in_ready(in_ready[4]),
    .in_res(in_res[4]), .in_last(in_last[4]), .out_valid(out_valid[4]),
    .out_ready(out_ready[4]), .out_sum(out_sum[4]), .out_count(out_count[4]),
    .out_ovf(out_ovf[4]));

  assign out_sum[1]   = {8'h00, sum_1};
  assign out_sum[2]   = {8'h00, sum_2};
  assign out_count[3] = {12'h000, cnt_3};

  function automatic void chk(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endfunction

  task automatic push_exp(input int k, input logic [71:0] s, input logic [15:0] c, input logic o);
    exp_t e;
    e.sum = s;
    e.cnt = c;
    e.ovf = o;
    exp_q[k].push_back(e);
  endtask

  // Drive one beat and hold it until accepted; returns 1 time unit after the accept edge
  task automatic send(input int k, input logic [63:0] v, input logic last);
    int n;
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_res[k]   = v;
    in_last[k]  = last;
    n = 0;
    while (!in_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready[k]) passes++;
    else $display("FAIL accept_timeout[%0d]: in_ready=%0b, required 1", k, in_ready[k]);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
  endtask

  // Monitor: compare every handed-off result against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < NI; k++) begin
          if (out_valid[k] && out_ready[k]) begin
            if (exp_q[k].size() == 0) begin
              checks++;
              $display("FAIL unexpected_result[%0d]: got sum %h, required no result", k, out_sum[k]);
            end else begin
              e = exp_q[k].pop_front();
              chk($sformatf("sum[%0d]", k), out_sum[k], e.sum);
              chk($sformatf("count[%0d]", k), 72'(out_count[k]), 72'(e.cnt));
              chk($sformatf("ovf[%0d]", k), 72'(out_ovf[k]), 72'(e.ovf));
            end
          end
        end
      end
    end
  end

  initial begin
    int  n;
    bit  busy;
    checks    = 0;
    passes    = 0;
    rst       = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    out_ready = '1;
    for (int k = 0; k < NI; k++) in_res[k] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_valid", 72'(out_valid[0]), 72'd0);
    chk("rst_ready", 72'(in_ready[0]), 72'd1);
    chk("rst_sum", out_sum[0], 72'd0);
    chk("rst_count", 72'(out_count[0]), 72'd0);

    // 6 + (-10) + 100, consumer ready
    send(0, 64'd6, 1'b0);
    send(0, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0);
    push_exp(0, 72'd96, 16'd3, 1'b0);
    send(0, 64'd100, 1'b1);
    chk("t1_valid_latency", 72'(out_valid[0]), 72'd1);
    chk("t1_ready_hold", 72'(in_ready[0]), 72'd0);
    @(posedge clk);
    #1;
    chk("t1_ready_back", 72'(in_ready[0]), 72'd1);
    chk("t1_valid_drop", 72'(out_valid[0]), 72'd0);

    // Same group with a stalled consumer and a pending beat of 7
    out_ready[0] = 1'b0;
    send(0, 64'd6, 1'b0);
    send(0, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0);
    push_exp(0, 72'd96, 16'd3, 1'b0);
    send(0, 64'd100, 1'b1);
    in_valid[0] = 1'b1;
    in_res[0]   = 64'd7;
    in_last[0]  = 1'b1;
    push_exp(0, 72'd7, 16'd1, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("t2_hold_sum", out_sum[0], 72'd96);
      chk("t2_hold_valid", 72'(out_valid[0]), 72'd1);
      chk("t2_hold_ready", 72'(in_ready[0]), 72'd0);
    end
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    send(0, 64'd7, 1'b1);
    repeat (3) @(posedge clk);

    // Reset mid-group discards two beats of 5
    send(0, 64'd5, 1'b0);
    send(0, 64'd5, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t5_valid", 72'(out_valid[0]), 72'd0);
    chk("t5_sum", out_sum[0], 72'd0);
    chk("t5_count", 72'(out_count[0]), 72'd0);
    chk("t5_ovf", 72'(out_ovf[0]), 72'd0);
    chk("t5_ready", 72'(in_ready[0]), 72'd1);
    push_exp(0, 72'd3, 16'd1, 1'b0);
    send(0, 64'd3, 1'b1);

    // 64-bit signed, saturating: positive then negative overflow
    push_exp(1, 72'h00_7FFF_FFFF_FFFF_FFFF, 16'd2, 1'b1);
    send(1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    send(1, 64'd1, 1'b1);
    push_exp(1, 72'h00_8000_0000_0000_0000, 16'd2, 1'b1);
    send(1, 64'h8000_0000_0000_0000, 1'b0);
    send(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    // 64-bit signed, wrapping
    push_exp(2, 72'h00_8000_0000_0000_0000, 16'd2, 1'b1);
    send(2, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    send(2, 64'd1, 1'b1);
    push_exp(2, 72'h00_7FFF_FFFF_FFFF_FFFF, 16'd2, 1'b1);
    send(2, 64'h8000_0000_0000_0000, 1'b0);
    send(2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    // Forced close at 15 beats; the 16th opens a new group
    push_exp(3, 72'd30, 16'd15, 1'b0);
    push_exp(3, 72'd4, 16'd2, 1'b0);
    repeat (16) send(3, 64'd2, 1'b0);
    send(3, 64'd2, 1'b1);

    // Unsigned: no carry out of a 72-bit accumulator
    push_exp(4, 72'h1_FFFF_FFFF_FFFF_FFFE, 16'd2, 1'b0);
    send(4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    // Drain the scoreboard within a bounded time
    n    = 0;
    busy = 1'b1;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
      busy = 1'b0;
      for (int k = 0; k < NI; k++) if (exp_q[k].size() != 0) busy = 1'b1;
    end
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (exp_q[k].size() == 0) passes++;
      else $display("FAIL drain[%0d]: %0d results outstanding, required 0", k, exp_q[k].size());
    end
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
